uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter.sv | 144 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : uart_tx_arbiter
//  Description : Round-robin arbiter that shares one uart_tx among N_REQ
//                byte-stream requesters, with message locking and lock timeout.
//  Revision    : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int N_REQ        = 4,
    parameter int LOCK_TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req_valid_i,
    input  logic [8*N_REQ-1:0]   req_data_i,
    input  logic [N_REQ-1:0]     req_last_i,
    output logic [N_REQ-1:0]     req_ready_o,
    output logic [7:0]           utx_data_o,
    output logic                 utx_start_o,
    input  logic                 utx_done_i,
    output logic [N_REQ-1:0]     grant_o,
    output logic                 busy_o,
    output logic                 timeout_o
);

    localparam int          c_PTR_W    = $clog2(N_REQ);
    localparam logic [1:0]  c_IDLE     = 2'd0;
    localparam logic [1:0]  c_LAUNCH   = 2'd1;
    localparam logic [1:0]  c_SEND     = 2'd2;
    localparam logic [15:0] c_TMO_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [N_REQ-1:0] c_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [c_PTR_W-1:0] r_rr_ptr;
    logic               r_lock;
    logic [c_PTR_W-1:0] r_lock_owner;
    logic [15:0]        r_tcnt;
    logic [7:0]         r_data;
    logic               r_last;
    logic               r_start;
    logic [N_REQ-1:0]   r_grant;
    logic               r_timeout;

    logic [N_REQ-1:0]   w_eligible;
    logic [N_REQ-1:0]   w_cand;
    logic [N_REQ-1:0]   w_win_oh;
    logic [c_PTR_W-1:0] w_win;
    logic               w_found;
    logic               w_accept;
    int                 w_idx;

    function automatic logic [c_PTR_W-1:0] f_next(input logic [c_PTR_W-1:0] p);
        if (int'(p) == N_REQ - 1) return '0;
        return p + c_PTR_W'(1);
    endfunction

    // While a message is locked only its owner may continue.
    assign w_eligible = r_lock ? (c_ONE << r_lock_owner) : '1;
    assign w_cand     = req_valid_i & w_eligible;

    always_comb begin
        w_win   = '0;
        w_found = 1'b0;
        w_idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= N_REQ) w_idx = w_idx - N_REQ;
            if (!w_found && w_cand[w_idx]) begin
                w_found = 1'b1;
                w_win   = c_PTR_W'(w_idx);
            end
        end
    end

    assign w_win_oh = c_ONE << w_win;
    assign w_accept = (r_state == c_IDLE) && utx_done_i && w_found;

    // Ready is combinational, so it is gated by rst_n to stay low during reset.
    assign req_ready_o = (w_accept && rst_n) ? w_win_oh : '0;
    assign utx_data_o  = r_data;
    assign utx_start_o = r_start;
    assign grant_o     = r_grant;
    assign busy_o      = (r_state != c_IDLE);
    assign timeout_o   = r_timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= c_IDLE;
            r_rr_ptr     <= '0;
            r_lock       <= 1'b0;
            r_lock_owner <= '0;
            r_tcnt       <= '0;
            r_data       <= '0;
            r_last       <= 1'b0;
            r_start      <= 1'b0;
            r_grant      <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_start   <= 1'b0;
            r_timeout <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_data  <= req_data_i[8*int'(w_win) +: 8];
                        r_last  <= req_last_i[w_win];
                        r_grant <= w_win_oh;
                        r_tcnt  <= '0;
                        r_start <= 1'b1;
                        r_state <= c_LAUNCH;
                        if (req_last_i[w_win]) begin
                            r_lock   <= 1'b0;
                            r_rr_ptr <= f_next(w_win);
                        end else begin
                            r_lock       <= 1'b1;
                            r_lock_owner <= w_win;
                        end
                    end else if (r_lock && !req_valid_i[r_lock_owner]) begin
                        // Owner went silent mid-message: release after LOCK_TIMEOUT idle cycles.
                        if (r_tcnt == c_TMO_LAST) begin
                            r_lock    <= 1'b0;
                            r_grant   <= '0;
                            r_timeout <= 1'b1;
                            r_rr_ptr  <= f_next(r_lock_owner);
                            r_tcnt    <= '0;
                        end else begin
                            r_tcnt <= r_tcnt + 16'd1;
                        end
                    end
                end
                c_LAUNCH: r_state <= c_SEND;
                c_SEND: begin
                    if (utx_done_i) begin
                        r_state <= c_IDLE;
                        if (r_last) r_grant <= '0;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_uart_tx_arbiter
//  Description : Scoreboard bench for uart_tx_arbiter with a behavioural uart_tx.
//  Revision    : 1.0
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int N   = 4;
    localparam int CPB = 10;
    localparam int TMO = 20;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic [7:0]     utx_data_o;
    logic           utx_start_o;
    logic           utx_done;
    logic [N-1:0]   grant_o;
    logic           busy_o;
    logic           timeout_o;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .LOCK_TIMEOUT(TMO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .utx_data_o  (utx_data_o),
        .utx_start_o (utx_start_o),
        .utx_done_i  (utx_done),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic sample();
        @(negedge clk);
        #2;
    endtask

    // Behavioural uart_tx (no reset, like the real one): 8N1, CPB clocks per bit.
    logic       hold_busy = 1'b0;
    logic       u_busy    = 1'b0;
    logic [9:0] u_sh      = 10'h3FF;
    int         u_clk     = 0;
    int         u_bit     = 0;
    logic       tx_line;
    assign utx_done = !u_busy && !hold_busy;
    assign tx_line  = u_busy ? u_sh[0] : 1'b1;

    always @(posedge clk) begin
        if (!u_busy) begin
            if (utx_start_o) begin
                u_busy <= 1'b1;
                u_sh   <= {1'b1, utx_data_o, 1'b0};
                u_clk  <= 0;
                u_bit  <= 0;
            end
        end else if (u_clk == CPB - 1) begin
            u_clk <= 0;
            u_sh  <= {1'b1, u_sh[9:1]};
            if (u_bit == 9) u_busy <= 1'b0;
            else u_bit <= u_bit + 1;
        end else begin
            u_clk <= u_clk + 1;
        end
    end

    // Requester byte queues.
    logic [8:0] rq_mem [N][16];
    int         rq_wr  [N] = '{default: 0};
    int         rq_rd  [N] = '{default: 0};
    logic [N-1:0] xfer_seen = '0;

    logic [11:0] sb_q [$];
    logic [7:0]  tx_q [$];

    task automatic push(input int k, input logic [7:0] d, input logic l);
        rq_mem[k][rq_wr[k] % 16] = {l, d};
        rq_wr[k]++;
    endtask

    task automatic expect_byte(input int k, input logic [7:0] d);
        logic [3:0] g;
        g = 4'b0001 << k;
        sb_q.push_back({g, d});
        tx_q.push_back(d);
    endtask

    function automatic logic pending();
        for (int k = 0; k < N; k++) if (rq_rd[k] != rq_wr[k]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) xfer_seen <= req_valid & req_ready;

    initial begin
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (xfer_seen[k]) rq_rd[k]++;
                req_valid[k] = (rq_rd[k] != rq_wr[k]);
                if (req_valid[k]) {req_last[k], req_data[8*k +: 8]} = rq_mem[k][rq_rd[k] % 16];
                else begin
                    req_last[k]        = 1'b0;
                    req_data[8*k +: 8] = 8'h00;
                end
            end
        end
    end

    // Start monitor: pops the scoreboard on every launch.
    initial begin
        logic        prev_done;
        logic [11:0] e;
        prev_done = 1'b1;
        forever begin
            sample();
            chk("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
            if (req_ready != '0) chk("ready_only_idle", 32'(busy_o), 32'd0);
            if (utx_start_o) begin
                chk("start_after_done", 32'(prev_done), 32'd1);
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL start_unexpected: got data %0h expected no start", utx_data_o);
                end else begin
                    e = sb_q.pop_front();
                    chk("start_data", 32'(utx_data_o), 32'(e[7:0]));
                    chk("start_grant", 32'(grant_o), 32'(e[11:8]));
                end
            end
            prev_done = utx_done;
        end
    end

    // Line monitor: decodes each frame on the tx line.
    initial begin
        logic       prev_tx;
        logic [7:0] b;
        prev_tx = 1'b1;
        forever begin
            sample();
            if (prev_tx && !tx_line) begin
                repeat (4) sample();
                chk("tx_start_bit", 32'(tx_line), 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) sample();
                    b[i] = tx_line;
                end
                repeat (CPB) sample();
                chk("tx_stop_bit", 32'(tx_line), 32'd1);
                if (tx_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL tx_unexpected: got byte %0h expected none", b);
                end else begin
                    chk("tx_byte", 32'(b), 32'(tx_q.pop_front()));
                end
            end
            prev_tx = tx_line;
        end
    end

    task automatic wait_quiet(input string tag);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || tx_q.size() != 0 || busy_o || !utx_done || pending()) && n < 5000) begin
            sample();
            n++;
        end
        chk({tag, "_quiet"}, 32'(n < 5000), 32'd1);
    endtask

    task automatic do_reset();
        sample();
        rst_n = 1'b0;
        repeat (2) sample();
        rst_n = 1'b1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grant"},   32'(grant_o),     32'd0);
        chk({tag, "_busy"},    32'(busy_o),      32'd0);
        chk({tag, "_start"},   32'(utx_start_o), 32'd0);
        chk({tag, "_data"},    32'(utx_data_o),  32'd0);
        chk({tag, "_ready"},   32'(req_ready),   32'd0);
        chk({tag, "_timeout"}, 32'(timeout_o),   32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (2) sample();
        chk_zero("reset");
        rst_n = 1'b1;

        // Single requester 2, byte A5, last.
        push(2, 8'hA5, 1'b1);
        expect_byte(2, 8'hA5);
        n = 0;
        while (req_ready == '0 && n < 20) begin sample(); n++; end
        chk("s1_ready", 32'(req_ready), 32'h4);
        chk("s1_grant_pre", 32'(grant_o), 32'h0);
        sample();
        chk("s1_start", 32'(utx_start_o), 32'd1);
        chk("s1_data", 32'(utx_data_o), 32'hA5);
        chk("s1_grant", 32'(grant_o), 32'h4);
        chk("s1_busy", 32'(busy_o), 32'd1);
        sample();
        chk("s1_start_once", 32'(utx_start_o), 32'd0);
        chk("s1_data_hold", 32'(utx_data_o), 32'hA5);
        chk("s1_grant_hold", 32'(grant_o), 32'h4);
        n = 0;
        while (grant_o != '0 && n < 300) begin sample(); n++; end
        chk("s1_grant_release", 32'(grant_o), 32'h0);
        chk("s1_done_at_release", 32'(utx_done), 32'd1);
        wait_quiet("s1");

        // All four valid, single-byte messages: round-robin 0,1,2,3,0.
        do_reset();
        push(0, 8'h10, 1'b1); push(0, 8'h14, 1'b1);
        push(1, 8'h11, 1'b1); push(2, 8'h12, 1'b1); push(3, 8'h13, 1'b1);
        expect_byte(0, 8'h10); expect_byte(1, 8'h11); expect_byte(2, 8'h12);
        expect_byte(3, 8'h13); expect_byte(0, 8'h14);
        wait_quiet("s2");

        // Pointer now at 1: req 1's 3-byte message is contiguous, then 3, then 0.
        push(0, 8'h20, 1'b1); push(3, 8'h23, 1'b1);
        push(1, 8'h31, 1'b0); push(1, 8'h32, 1'b0); push(1, 8'h33, 1'b1);
        expect_byte(1, 8'h31); expect_byte(1, 8'h32); expect_byte(1, 8'h33);
        expect_byte(3, 8'h23); expect_byte(0, 8'h20);
        wait_quiet("s3");

        // Lock timeout: req 0 locks then goes silent; req 1 waits.
        do_reset();
        push(0, 8'h40, 1'b0);
        expect_byte(0, 8'h40);
        n = 0;
        while ((sb_q.size() != 0 || busy_o) && n < 500) begin sample(); n++; end
        chk("s4_lock_grant", 32'(grant_o), 32'h1);
        push(1, 8'h50, 1'b1);
        expect_byte(1, 8'h50);
        n = 0;
        while (!timeout_o && n < 40) begin sample(); n++; end
        chk("s4_timeout_cycles", 32'(n), 32'(TMO));
        chk("s4_timeout_grant", 32'(grant_o), 32'h0);
        chk("s4_ready_after", 32'(req_ready), 32'h2);
        sample();
        chk("s4_timeout_pulse", 32'(timeout_o), 32'd0);
        wait_quiet("s4");

        // Reset mid-SEND with the transmitter still reported busy.
        push(2, 8'h60, 1'b1);
        expect_byte(2, 8'h60);
        n = 0;
        while (!utx_start_o && n < 50) begin sample(); n++; end
        chk("s5_started", 32'(utx_start_o), 32'd1);
        repeat (5) sample();
        hold_busy = 1'b1;
        rst_n     = 1'b0;
        #1;
        chk_zero("s5_reset");
        sample();
        rst_n = 1'b1;
        push(3, 8'h70, 1'b1);
        expect_byte(3, 8'h70);
        repeat (30) begin
            sample();
            chk("s5_no_start", {30'd0, utx_start_o, |req_ready}, 32'd0);
        end
        hold_busy = 1'b0;
        wait_quiet("s5");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
